// File: rtl/packet_fifo_sf.sv
// Store-and-forward packet FIFO: a packet is readable only after a clean EOP.
// Errored, truncated and oversize packets are discarded by rewinding the write pointer.
module packet_fifo_sf #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2048,
    parameter int MAX_PKTS   = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int CNT_WIDTH  = $clog2(MAX_PKTS) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    input  logic                  wr_sop,
    input  logic                  wr_eop,
    input  logic                  wr_err,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_sop,
    output logic                  rd_eop,
    input  logic                  rd_ready,
    output logic [ADDR_WIDTH:0]   level,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic [15:0]           drop_count,
    output logic                  drop_pulse
);
    typedef enum logic [1:0] {IDLE, STORE, DISCARD} wr_state_e;

    localparam logic [ADDR_WIDTH:0]  DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] MAX_L   = CNT_WIDTH'(MAX_PKTS);

    wr_state_e                 state_q, state_d;
    logic [ADDR_WIDTH:0]       wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]       commit_ptr_q, commit_ptr_d;
    logic [ADDR_WIDTH:0]       rd_ptr_q;
    logic [ADDR_WIDTH:0]       pop_ptr_q;
    logic [CNT_WIDTH-1:0]      pkt_count_q;
    logic [15:0]               drop_count_q;
    logic                      drop_pulse_q;

    logic                      mem_we;
    logic [ADDR_WIDTH-1:0]     mem_waddr;
    logic                      drop;
    logic                      commit;
    logic                      mem_full;
    logic                      committed_full;

    logic [DATA_WIDTH:0]       mem [DEPTH];
    logic [DATA_WIDTH:0]       mem_rdata_q;
    logic                      mem_vld_q;
    logic [DATA_WIDTH:0]       skid_q;
    logic                      skid_vld_q;
    logic [DATA_WIDTH:0]       out_q;
    logic                      out_vld_q;
    logic                      out_sop_q;
    logic                      first_q;

    logic                      pop;
    logic                      fetch;
    logic [1:0]                occ;
    logic                      out_free;
    logic                      load_vld;
    logic [DATA_WIDTH:0]       load_word;

    // Slots stay occupied until popped, so the prefetch stages count towards level.
    assign level          = wr_ptr_q - pop_ptr_q;
    assign mem_full       = (level == DEPTH_L);
    assign committed_full = ((commit_ptr_q - pop_ptr_q) == DEPTH_L);

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        mem_we       = 1'b0;
        mem_waddr    = wr_ptr_q[ADDR_WIDTH-1:0];
        drop         = 1'b0;
        commit       = 1'b0;
        if (wr_valid) begin
            if (wr_sop) begin
                // Every SOP restarts at the commit point; a partial packet is dropped.
                wr_ptr_d  = commit_ptr_q;
                mem_waddr = commit_ptr_q[ADDR_WIDTH-1:0];
                drop      = (state_q == STORE);
                if (pkt_count_q == MAX_L || committed_full) begin
                    drop    = 1'b1;
                    state_d = wr_eop ? IDLE : DISCARD;
                end else if (wr_eop) begin
                    mem_we  = 1'b1;
                    state_d = IDLE;
                    if (wr_err) begin
                        drop = 1'b1;
                    end else begin
                        commit       = 1'b1;
                        wr_ptr_d     = commit_ptr_q + 1'b1;
                        commit_ptr_d = commit_ptr_q + 1'b1;
                    end
                end else begin
                    mem_we   = 1'b1;
                    wr_ptr_d = commit_ptr_q + 1'b1;
                    state_d  = STORE;
                end
            end else if (state_q == STORE) begin
                if (mem_full) begin
                    drop     = 1'b1;
                    wr_ptr_d = commit_ptr_q;
                    state_d  = wr_eop ? IDLE : DISCARD;
                end else begin
                    mem_we = 1'b1;
                    if (wr_eop) begin
                        state_d = IDLE;
                        if (wr_err) begin
                            drop     = 1'b1;
                            wr_ptr_d = commit_ptr_q;
                        end else begin
                            commit       = 1'b1;
                            wr_ptr_d     = wr_ptr_q + 1'b1;
                            commit_ptr_d = wr_ptr_q + 1'b1;
                        end
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end else if (state_q == DISCARD && wr_eop) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            pkt_count_q  <= '0;
            drop_count_q <= '0;
            drop_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            drop_pulse_q <= drop;
            if (drop && drop_count_q != 16'hFFFF) begin
                drop_count_q <= drop_count_q + 1'b1;
            end
            if (commit && !(pop && out_q[DATA_WIDTH])) begin
                pkt_count_q <= pkt_count_q + 1'b1;
            end else if (!commit && pop && out_q[DATA_WIDTH]) begin
                pkt_count_q <= pkt_count_q - 1'b1;
            end
        end
    end

    // Fetch only while the output and skid registers can absorb everything in flight.
    assign pop       = out_vld_q && rd_ready;
    assign occ       = 2'(out_vld_q) + 2'(skid_vld_q) + 2'(mem_vld_q);
    assign fetch     = (rd_ptr_q != commit_ptr_q) && ((occ - 2'(pop)) < 2'd2);
    assign out_free  = !out_vld_q || pop;
    assign load_vld  = skid_vld_q || mem_vld_q;
    assign load_word = skid_vld_q ? skid_q : mem_rdata_q;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= {wr_eop, wr_data};
        end
        if (fetch) begin
            mem_rdata_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            pop_ptr_q  <= '0;
            mem_vld_q  <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            out_sop_q  <= 1'b0;
            first_q    <= 1'b1;
        end else begin
            mem_vld_q <= fetch;
            if (fetch) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (pop) begin
                pop_ptr_q <= pop_ptr_q + 1'b1;
            end
            if (out_free) begin
                out_vld_q <= load_vld;
                if (load_vld) begin
                    out_q     <= load_word;
                    out_sop_q <= first_q;
                    first_q   <= load_word[DATA_WIDTH];
                end
                skid_vld_q <= skid_vld_q && mem_vld_q;
                if (skid_vld_q && mem_vld_q) begin
                    skid_q <= mem_rdata_q;
                end
            end else if (mem_vld_q) begin
                skid_vld_q <= 1'b1;
                skid_q     <= mem_rdata_q;
            end
        end
    end

    assign wr_ready   = 1'b1;
    assign rd_data    = out_q[DATA_WIDTH-1:0];
    assign rd_valid   = out_vld_q;
    assign rd_sop     = out_vld_q && out_sop_q;
    assign rd_eop     = out_vld_q && out_q[DATA_WIDTH];
    assign pkt_count  = pkt_count_q;
    assign drop_count = drop_count_q;
    assign drop_pulse = drop_pulse_q;

endmodule

// File: tb/tb_packet_fifo_sf.sv
// Bench for packet_fifo_sf: directed and random packets scored against a queue-based
// model of the commit/drop rules, with per-cycle checks of level and counters.
module tb_packet_fifo_sf;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int MAXP  = 4;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(MAXP) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] wr_data;
    logic          wr_valid, wr_sop, wr_eop, wr_err, wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid, rd_sop, rd_eop, rd_ready;
    logic [AW:0]   level;
    logic [CW-1:0] pkt_count;
    logic [15:0]   drop_count;
    logic          drop_pulse;

    packet_fifo_sf #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_PKTS(MAXP)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_sop(wr_sop), .wr_eop(wr_eop),
        .wr_err(wr_err), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_sop(rd_sop), .rd_eop(rd_eop),
        .rd_ready(rd_ready), .level(level), .pkt_count(pkt_count),
        .drop_count(drop_count), .drop_pulse(drop_pulse)
    );

    always #5 clk = ~clk;

    typedef enum {M_IDLE, M_STORE, M_DISCARD} mode_e;

    int            nCmp = 0;
    int            nMis = 0;
    logic [DW+1:0] expQ[$];
    logic [DW-1:0] curPkt[$];
    int            committed = 0;
    int            pkts = 0;
    int            drops = 0;
    bit            pulseExp = 1'b0;
    mode_e         mode = M_IDLE;
    bit            prevStall = 1'b0;
    logic [DW+1:0] prevBeat = '0;
    int            dropsBefore;
    bit            sawValid;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nMis++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit pickReady(input int m);
        return (m == 0) ? 1'b0 : ((m == 1) ? 1'b1 : 1'($urandom));
    endfunction

    task automatic clearModel();
        expQ.delete();
        curPkt.delete();
        committed = 0;
        pkts      = 0;
        drops     = 0;
        pulseExp  = 1'b0;
        mode      = M_IDLE;
        prevStall = 1'b0;
    endtask

    task automatic checkResetValues(input string pfx);
        checkOutput({pfx, "_rd_valid"},   32'(rd_valid),   32'd0);
        checkOutput({pfx, "_rd_sop"},     32'(rd_sop),     32'd0);
        checkOutput({pfx, "_rd_eop"},     32'(rd_eop),     32'd0);
        checkOutput({pfx, "_rd_data"},    32'(rd_data),    32'd0);
        checkOutput({pfx, "_level"},      32'(level),      32'd0);
        checkOutput({pfx, "_pkt_count"},  32'(pkt_count),  32'd0);
        checkOutput({pfx, "_drop_count"}, 32'(drop_count), 32'd0);
        checkOutput({pfx, "_drop_pulse"}, 32'(drop_pulse), 32'd0);
        checkOutput({pfx, "_wr_ready"},   32'(wr_ready),   32'd1);
    endtask

    // A packet is accepted whole or not at all; accepted beats join the expected stream.
    task automatic finishPkt(input bit er, inout bit drop);
        mode = M_IDLE;
        if (er) begin
            drop = 1'b1;
        end else begin
            for (int i = 0; i < curPkt.size(); i++) begin
                expQ.push_back({curPkt[i], i == 0, i == curPkt.size() - 1});
            end
            committed += curPkt.size();
            pkts++;
        end
        curPkt.delete();
    endtask

    task automatic applyStimulus(input bit v, input bit s, input bit e, input bit er,
                                 input logic [DW-1:0] d, input bit rdy);
        logic [DW+1:0] obsBeat;
        logic [31:0]   expBeat;
        int            lvlPre, comPre, pktsPre;
        bit            drop;
        @(posedge clk);
        #1;
        wr_valid = v; wr_sop = s; wr_eop = e; wr_err = er; wr_data = d; rd_ready = rdy;
        @(negedge clk);
        checkOutput("level",      32'(level),      32'(committed + curPkt.size()));
        checkOutput("pkt_count",  32'(pkt_count),  32'(pkts));
        checkOutput("drop_count", 32'(drop_count), 32'(drops));
        checkOutput("drop_pulse", 32'(drop_pulse), 32'(pulseExp));
        obsBeat = {rd_data, rd_sop, rd_eop};
        if (prevStall) begin
            checkOutput("hold_valid", 32'(rd_valid), 32'd1);
            checkOutput("hold_beat",  32'(obsBeat),  32'(prevBeat));
        end
        prevStall = rd_valid && !rd_ready;
        prevBeat  = obsBeat;

        lvlPre  = committed + curPkt.size();
        comPre  = committed;
        pktsPre = pkts;
        drop    = 1'b0;
        if (rd_valid && rd_ready) begin
            expBeat = 32'hFFFF_FFFF;
            if (expQ.size() != 0) begin
                expBeat = 32'(expQ.pop_front());
                committed--;
                if (expBeat[0]) pkts--;
            end
            checkOutput("rd_beat", 32'(obsBeat), expBeat);
        end
        if (v) begin
            if (s) begin
                if (mode == M_STORE) drop = 1'b1;
                curPkt.delete();
                if (pktsPre == MAXP || comPre == DEPTH) begin
                    drop = 1'b1;
                    mode = e ? M_IDLE : M_DISCARD;
                end else begin
                    curPkt.push_back(d);
                    if (e) finishPkt(er, drop);
                    else   mode = M_STORE;
                end
            end else if (mode == M_STORE) begin
                if (lvlPre == DEPTH) begin
                    drop = 1'b1;
                    curPkt.delete();
                    mode = e ? M_IDLE : M_DISCARD;
                end else begin
                    curPkt.push_back(d);
                    if (e) finishPkt(er, drop);
                end
            end else if (mode == M_DISCARD && e) begin
                mode = M_IDLE;
            end
        end
        if (drop) drops++;
        pulseExp = drop;
    endtask

    task automatic idle(input int n, input int rmode);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), DW'($urandom), pickReady(rmode));
        end
    endtask

    // wr_err is randomised on non-EOP beats since it must only matter with EOP.
    task automatic sendPkt(input int len, input bit err, input bit term, input int rmode);
        bit last;
        for (int i = 0; i < len; i++) begin
            last = term && (i == len - 1);
            applyStimulus(1'b1, i == 0, last, last ? err : 1'($urandom), DW'($urandom), pickReady(rmode));
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((expQ.size() != 0 || rd_valid) && n < 300) begin
            idle(1, 1);
            n++;
        end
        checkOutput("drain_done", 32'(expQ.size()), 32'd0);
    endtask

    task automatic doReset();
        wr_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1 checkResetValues("mid_rst");
        clearModel();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        wr_valid = 1'b0; wr_sop = 1'b0; wr_eop = 1'b0; wr_err = 1'b0; wr_data = '0; rd_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 checkResetValues("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] back-to-back good packets");
        sendPkt(1, 1'b0, 1'b1, 1);
        sendPkt(5, 1'b0, 1'b1, 1);
        sendPkt(12, 1'b0, 1'b1, 1);
        drain();
        checkOutput("b2b_drops", 32'(drop_count), 32'd0);

        $display("[TB] errored packet then good packet");
        dropsBefore = drops;
        sendPkt(10, 1'b1, 1'b1, 1);
        sendPkt(5, 1'b0, 1'b1, 1);
        drain();
        checkOutput("err_drops", 32'(drop_count), 32'(dropsBefore + 1));

        $display("[TB] oversize packet then exactly-full packet");
        dropsBefore = drops;
        sendPkt(20, 1'b0, 1'b1, 0);
        checkOutput("ovl_drops", 32'(drop_count), 32'(dropsBefore + 1));
        sendPkt(DEPTH, 1'b0, 1'b1, 0);
        idle(1, 0);
        checkOutput("full_pkt_level", 32'(level), 32'(DEPTH));
        checkOutput("full_pkt_count", 32'(pkt_count), 32'd1);
        drain();

        $display("[TB] packet slot limit");
        dropsBefore = drops;
        for (int i = 0; i < 6; i++) sendPkt(2, 1'b0, 1'b1, 0);
        idle(1, 0);
        checkOutput("max_pkt_count", 32'(pkt_count), 32'(MAXP));
        checkOutput("max_drops", 32'(drop_count), 32'(dropsBefore + 2));
        drain();

        $display("[TB] SOP restart of an unterminated packet");
        dropsBefore = drops;
        sendPkt(3, 1'b0, 1'b0, 2);
        sendPkt(4, 1'b0, 1'b1, 2);
        idle(6, 2);
        drain();
        checkOutput("restart_drops", 32'(drop_count), 32'(dropsBefore + 1));

        $display("[TB] commit-to-output latency");
        sendPkt(1, 1'b0, 1'b1, 1);
        sawValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle(1, 1);
            sawValid |= rd_valid;
        end
        checkOutput("latency", 32'(sawValid), 32'd1);
        drain();

        $display("[TB] random traffic");
        for (int p = 0; p < 40; p++) begin
            int kind;
            int len;
            kind = $urandom_range(0, 9);
            len  = $urandom_range(1, 20);
            if (kind == 0)      sendPkt(len, 1'b0, 1'b0, 2);
            else if (kind == 1) sendPkt(len, 1'b1, 1'b1, 2);
            else if (kind == 2) applyStimulus(1'b1, 1'b0, 1'($urandom), 1'($urandom), DW'($urandom), pickReady(2));
            else                sendPkt(len, 1'b0, 1'b1, 2);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4), 2);
        end
        sendPkt(2, 1'b0, 1'b1, 2);
        drain();

        $display("[TB] reset during read-out");
        sendPkt(3, 1'b0, 1'b1, 0);
        sendPkt(4, 1'b0, 1'b1, 0);
        idle(3, 0);
        idle(1, 1);
        doReset();
        sendPkt(6, 1'b0, 1'b1, 2);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
        $finish;
    end

endmodule
